// File: rtl/fpga_reg_loader.sv
// Button-driven 32-bit operand loader: debounces btn, captures sw in two halves, writes TARGET_REG while stalling the CPU.
// Optional feature macro LOADER_ECHO_EN: registered echo of the last captured half.
module fpga_reg_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter logic [3:0]  TARGET_REG      = 4'b0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic        wr_req,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        wr_ack,
  output logic        cpu_hold,
  output logic [1:0]  phase,
  output logic [15:0] echo
);

  typedef enum logic [1:0] {
    LOAD_LO = 2'b00,
    LOAD_HI = 2'b01,
    WRITE   = 2'b10,
    RUN     = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [31:0]      data_q, data_d;

  // The level flips on the mismatch cycle after the counter has seen DEBOUNCE_CYCLES mismatches.
  always_comb begin
    cnt_d   = '0;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d   = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      LOAD_LO: begin
        if (press_q) begin
          data_d[15:0] = sw;
          state_d      = LOAD_HI;
        end
      end
      LOAD_HI: begin
        if (press_q) begin
          data_d[31:16] = sw;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        if (wr_ack) state_d = RUN;
      end
      RUN: begin
        if (press_q) state_d = LOAD_LO;
      end
      default: state_d = LOAD_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_LO;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign wr_req   = (state_q == WRITE);
  assign cpu_hold = (state_q != RUN);
  assign phase    = state_q;
  assign wr_addr  = TARGET_REG;
  assign wr_data  = data_q;

`ifdef LOADER_ECHO_EN
  logic        capture;
  logic [15:0] echo_q;

  assign capture = press_q && ((state_q == LOAD_LO) || (state_q == LOAD_HI));

  always_ff @(posedge clk) begin
    if (reset) begin
      echo_q <= '0;
    end else if (capture) begin
      echo_q <= sw;
    end
  end

  // Once both halves are in, the display reverts to the low half of the operand.
  assign echo = ((state_q == WRITE) || (state_q == RUN)) ? data_q[15:0] : echo_q;
`else
  assign echo = 16'h0000;
`endif

endmodule

// File: tb/tb_fpga_reg_loader.sv
// Randomized bench for fpga_reg_loader against a sample-window debounce model and a phase-level loader model.
module tb_fpga_reg_loader;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw;
  logic        btn;
  logic        wr_req;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        cpu_hold;
  logic [1:0]  phase;
  logic [15:0] echo;

  always #5 clk = ~clk;

  fpga_reg_loader #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3),
    .TARGET_REG(4'b0001)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .btn(btn),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .cpu_hold(cpu_hold),
    .phase(phase),
    .echo(echo)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: btn samples per edge, newest first; debounced level flips once
  // D+1 consecutive synchronized samples disagree with it.
  bit          hist [0:D+1];
  bit          deb_m, press_m;
  int          st_m;
  logic [31:0] data_m;
  logic [15:0] echo_m;

  function automatic logic [15:0] exp_echo();
`ifdef LOADER_ECHO_EN
    return (st_m >= 2) ? data_m[15:0] : echo_m;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_edge();
    bit p;
    bit flip;
    if (reset) begin
      for (int i = 0; i <= D + 1; i++) hist[i] = 1'b0;
      deb_m = 0; press_m = 0; st_m = 0; data_m = '0; echo_m = '0;
      return;
    end
    p = press_m;
    case (st_m)
      0: if (p) begin data_m[15:0]  = sw; echo_m = sw; st_m = 1; end
      1: if (p) begin data_m[31:16] = sw; echo_m = sw; st_m = 2; end
      2: if (wr_ack) st_m = 3;
      default: if (p) st_m = 0;
    endcase
    flip = 1'b1;
    for (int i = 1; i <= D + 1; i++) if (hist[i] == deb_m) flip = 1'b0;
    press_m = flip && !deb_m;
    if (flip) deb_m = !deb_m;
    for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = btn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("phase",    32'(phase),    32'(st_m));
    check("cpu_hold", 32'(cpu_hold), 32'(st_m != 3));
    check("wr_req",   32'(wr_req),   32'(st_m == 2));
    check("wr_addr",  32'(wr_addr),  32'h1);
    check("wr_data",  wr_data,       data_m);
    check("echo",     32'(echo),     32'(exp_echo()));
  endtask

  task automatic press(input logic [15:0] v, output int lat);
    logic [1:0] start;
    start = phase;
    lat   = -1;
    sw    = v;
    btn   = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (phase != start) begin
        lat = i;
        break;
      end
    end
    check("press_seen", 32'(lat > 0), 32'h1);
  endtask

  task automatic release_btn();
    btn = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, req_cnt, first;
    logic [15:0] a, b;
    for (int i = 0; i <= D + 1; i++) hist[i] = 1'b0;
    deb_m = 0; press_m = 0; st_m = 0; data_m = '0; echo_m = '0;
    reset = 1'b1; btn = 1'b0; sw = 16'hFFFF; wr_ack = 1'b0;

    // Reset release with switches all high and button idle
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("rst_phase",    32'(phase),    32'h0);
    check("rst_hold",     32'(cpu_hold), 32'h1);
    check("rst_req",      32'(wr_req),   32'h0);
    check("rst_data",     wr_data,       32'h0);

    // Full load: low half, high half, ack one cycle after wr_req rises
    press(16'h5678, lat);
    check("press_latency", 32'(lat), 32'(2 + D + 2));
    check("lo_captured", {16'h0, wr_data[15:0]}, 32'h5678);
    release_btn();
    press(16'h1234, lat);
    req_cnt = wr_req ? 1 : 0;
    tick();
    if (wr_req) req_cnt++;
    wr_ack = 1'b1;
    tick();
    if (wr_req) req_cnt++;
    wr_ack = 1'b0;
    check("req_cycles", 32'(req_cnt), 32'h2);
    check("full_data",  wr_data,      32'h12345678);
    check("full_addr",  32'(wr_addr), 32'h1);
    check("run_phase",  32'(phase),   32'h3);
    check("run_hold",   32'(cpu_hold),32'h0);
    release_btn();
    check("release_no_press", 32'(phase), 32'h3);

    // Bounce rejection, then reload from RUN
    btn = 1'b1; tick();
    btn = 1'b0; tick();
    btn = 1'b1; tick();
    btn = 1'b0; tick();
    btn = 1'b1;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (first < 0 && phase != 2'b11) first = i;
    end
    check("bounce_latency", 32'(first), 32'h8);
    check("bounce_single",  32'(phase), 32'h0);
    check("reload_hold",    32'(cpu_hold), 32'h1);
    check("reload_keeps",   wr_data,    32'h12345678);
    release_btn();

    // Ack stall in WRITE
    a = 16'($urandom);
    b = 16'($urandom);
    press(a, lat);
    release_btn();
    press(b, lat);
    btn = 1'b0;
    repeat (50) tick();
    check("stall_req",  32'(wr_req),   32'h1);
    check("stall_data", wr_data,       {b, a});
    check("stall_hold", 32'(cpu_hold), 32'h1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("stall_run", 32'(phase), 32'h3);
    release_btn();

    // Reset mid-WRITE
    press(16'hA5A5, lat); release_btn();
    press(16'h0F0F, lat); release_btn();
    press(16'hF0F0, lat); release_btn();
    check("pre_rst_req", 32'(wr_req), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midw_req",   32'(wr_req), 32'h0);
    check("midw_phase", 32'(phase),  32'h0);
    check("midw_data",  wr_data,     32'h0);

    // Random button activity, acks and occasional resets
    for (int s = 0; s < 500; s++) begin
      int len;
      btn = 1'($urandom_range(0, 1));
      sw  = 16'($urandom);
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        wr_ack = ($urandom_range(0, 3) == 0);
        reset  = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    reset = 1'b0; wr_ack = 1'b0; btn = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
